// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: records register-file writes (pc, rd, data) into a
// circular buffer with stop/wrap capture, trigger + post window, and FIFO readout.
//
// state   | meaning
// IDLE    | waiting for arm, nothing captured
// CAPTURE | storing writebacks, trigger armed
// POST    | trigger seen, storing the post-trigger window
// DONE    | capture ended, entries drain oldest-first
module wb_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int POST_TRIG = 4,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       wb_valid,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic [REG_AW-1:0]          wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       trig_en,
  input  logic [REG_AW-1:0]          trig_rd,
  input  logic                       trig_data_en,
  input  logic [XLEN-1:0]            trig_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [REG_AW-1:0]          rd_reg,
  output logic [XLEN-1:0]            rd_data,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       triggered,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, post_q;
  logic              overflow_q, triggered_q;
  logic [CNT_W-1:0]  cycle_cnt_q, retire_cnt_q;

  logic [PC_W-1:0]   mem_pc_q   [DEPTH];
  logic [REG_AW-1:0] mem_rd_q   [DEPTH];
  logic [XLEN-1:0]   mem_data_q [DEPTH];

  logic active, capturable, full, drop, store, trig_hit, pop;

  assign active     = (state_q == S_CAPTURE) || (state_q == S_POST);
  // arm and reset both take priority over a same-cycle writeback
  assign capturable = active && wb_valid && (wb_rd != '0) && !arm && !reset;
  assign full       = (count_q == CW'(DEPTH));
  assign drop       = capturable && full && (WRAP_MODE == 0);
  assign store      = capturable && !drop;
  assign trig_hit   = (state_q == S_CAPTURE) && trig_en && (wb_rd == trig_rd) &&
                      (!trig_data_en || (wb_data == trig_data));

  assign rd_valid   = (state_q == S_DONE) && (count_q != '0);
  assign pop        = rd_valid && rd_ready;
  assign rd_pc      = rd_valid ? mem_pc_q[rptr_q]   : '0;
  assign rd_reg     = rd_valid ? mem_rd_q[rptr_q]   : '0;
  assign rd_data    = rd_valid ? mem_data_q[rptr_q] : '0;

  assign state      = state_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign triggered  = triggered_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

  always_ff @(posedge clk) begin
    if (store) begin
      mem_pc_q[wptr_q]   <= wb_pc;
      mem_rd_q[wptr_q]   <= wb_rd;
      mem_data_q[wptr_q] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      post_q       <= '0;
      overflow_q   <= 1'b0;
      triggered_q  <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else if (arm) begin
      state_q      <= S_CAPTURE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      post_q       <= '0;
      overflow_q   <= 1'b0;
      triggered_q  <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      case (state_q)
        S_CAPTURE, S_POST: begin
          if (!(&cycle_cnt_q)) cycle_cnt_q <= cycle_cnt_q + 1'b1;
          if (wb_valid && !(&retire_cnt_q)) retire_cnt_q <= retire_cnt_q + 1'b1;
          if (drop) begin
            overflow_q <= 1'b1;
            state_q    <= S_DONE;
          end else if (store) begin
            wptr_q <= wptr_q + 1'b1;
            // a full wrap-mode buffer overwrites the oldest entry
            if (full) begin
              rptr_q     <= rptr_q + 1'b1;
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + 1'b1;
            end
            if (trig_hit) begin
              triggered_q <= 1'b1;
              if (POST_TRIG == 0) begin
                state_q <= S_DONE;
              end else begin
                state_q <= S_POST;
                post_q  <= CW'(POST_TRIG);
              end
            end else if (state_q == S_POST) begin
              post_q <= post_q - 1'b1;
              if (post_q == CW'(1)) state_q <= S_DONE;
            end
          end
          if (stop) state_q <= S_DONE;
        end
        S_DONE: begin
          if (pop) begin
            rptr_q  <= rptr_q + 1'b1;
            count_q <= count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: three instances (deep stop-mode, shallow stop, shallow wrap)
// share one directed stimulus and are checked every cycle against a queue-based model.
module tb_wb_trace_buffer;

  localparam int NI = 3;
  localparam int DEP [NI] = '{16, 4, 4};
  localparam int WM  [NI] = '{0, 0, 1};
  localparam int PT  [NI] = '{2, 1, 1};

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, arm = 1'b0, stop = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0, wb_data = '0, trig_data = '0;
  logic [4:0]  wb_rd = '0, trig_rd = '0;
  logic        trig_en = 1'b0, trig_data_en = 1'b0, rd_ready = 1'b0;

  logic        rd_valid_w  [NI];
  logic [31:0] rd_pc_w     [NI];
  logic [4:0]  rd_reg_w    [NI];
  logic [31:0] rd_data_w   [NI];
  logic [1:0]  state_w     [NI];
  logic [4:0]  count_w     [NI];
  logic        overflow_w  [NI];
  logic        triggered_w [NI];
  logic [31:0] cycle_w     [NI];
  logic [31:0] retire_w    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CWG = $clog2(DEP[g] + 1);
    logic [CWG-1:0] cnt;
    wb_trace_buffer #(
      .XLEN(32), .PC_W(32), .REG_AW(5), .DEPTH(DEP[g]),
      .WRAP_MODE(WM[g]), .POST_TRIG(PT[g]), .CNT_W(32)
    ) u_dut (
      .clk(clk), .reset(reset), .arm(arm), .stop(stop),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
      .trig_en(trig_en), .trig_rd(trig_rd), .trig_data_en(trig_data_en),
      .trig_data(trig_data),
      .rd_valid(rd_valid_w[g]), .rd_ready(rd_ready),
      .rd_pc(rd_pc_w[g]), .rd_reg(rd_reg_w[g]), .rd_data(rd_data_w[g]),
      .state(state_w[g]), .count(cnt), .overflow(overflow_w[g]),
      .triggered(triggered_w[g]), .cycle_cnt(cycle_w[g]), .retire_cnt(retire_w[g])
    );
    assign count_w[g] = 5'(cnt);
  end

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, g, $time, act, exp);
    end
  endtask

  // Model: captured entries live in a queue; state is 0..3 as on the state port.
  ent_t        mq [NI][$];
  int          m_st   [NI];
  int          m_post [NI];
  logic        m_ovf  [NI];
  logic        m_trg  [NI];
  logic [31:0] m_cyc  [NI];
  logic [31:0] m_ret  [NI];

  initial begin
    for (int g = 0; g < NI; g++) begin
      m_st[g] = 0; m_post[g] = 0; m_ovf[g] = 0; m_trg[g] = 0; m_cyc[g] = 0; m_ret[g] = 0;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < NI; g++) begin
        if (reset || arm) begin
          mq[g].delete();
          m_st[g] = reset ? 0 : 1;
          m_post[g] = 0; m_ovf[g] = 0; m_trg[g] = 0; m_cyc[g] = 0; m_ret[g] = 0;
        end else if (m_st[g] == 1 || m_st[g] == 2) begin
          int nst;
          nst = m_st[g];
          if (m_cyc[g] != 32'hFFFF_FFFF) m_cyc[g] = m_cyc[g] + 1;
          if (wb_valid && m_ret[g] != 32'hFFFF_FFFF) m_ret[g] = m_ret[g] + 1;
          if (wb_valid && wb_rd != 0) begin
            bit hit;
            hit = (m_st[g] == 1) && trig_en && (wb_rd == trig_rd) &&
                  (!trig_data_en || wb_data == trig_data);
            if (mq[g].size() == DEP[g] && WM[g] == 0) begin
              m_ovf[g] = 1; nst = 3;
            end else begin
              ent_t e;
              e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
              if (mq[g].size() == DEP[g]) begin
                void'(mq[g].pop_front());
                m_ovf[g] = 1;
              end
              mq[g].push_back(e);
              if (hit) begin
                m_trg[g] = 1;
                if (PT[g] == 0) nst = 3;
                else begin nst = 2; m_post[g] = PT[g]; end
              end else if (m_st[g] == 2) begin
                m_post[g] = m_post[g] - 1;
                if (m_post[g] == 0) nst = 3;
              end
            end
          end
          if (stop) nst = 3;
          m_st[g] = nst;
        end else if (m_st[g] == 3) begin
          if (mq[g].size() > 0 && rd_ready) void'(mq[g].pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int g = 0; g < NI; g++) begin
          ent_t e;
          logic v;
          v = (m_st[g] == 3) && (mq[g].size() > 0);
          e = v ? mq[g][0] : '0;
          chk("state", g, 32'(state_w[g]), 32'(m_st[g]));
          chk("count", g, 32'(count_w[g]), 32'(mq[g].size()));
          chk("overflow", g, 32'(overflow_w[g]), 32'(m_ovf[g]));
          chk("triggered", g, 32'(triggered_w[g]), 32'(m_trg[g]));
          chk("cycle_cnt", g, cycle_w[g], m_cyc[g]);
          chk("retire_cnt", g, retire_w[g], m_ret[g]);
          chk("rd_valid", g, 32'(rd_valid_w[g]), 32'(v));
          chk("rd_pc", g, rd_pc_w[g], e.pc);
          chk("rd_reg", g, 32'(rd_reg_w[g]), 32'(e.rd));
          chk("rd_data", g, rd_data_w[g], e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = d;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    logic [4:0]  t_reg  [4];
    logic [31:0] t_data [4];

    step(); step();
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("lit_reset_state", 0, 32'(state_w[0]), 32'd0);
    chk("lit_reset_count", 0, 32'(count_w[0]), 32'd0);
    chk("lit_reset_rd_data", 0, rd_data_w[0], 32'd0);
    pulse_stop();
    chk("lit_idle_stop", 0, 32'(state_w[0]), 32'd0);

    // basic capture and readout
    pulse_arm();
    ev(32'h0, 5'd1, 32'd5);
    ev(32'h4, 5'd2, 32'd10);
    ev(32'h8, 5'd3, 32'd15);
    pulse_stop();
    chk("lit_basic_state", 0, 32'(state_w[0]), 32'd3);
    chk("lit_basic_count", 0, 32'(count_w[0]), 32'd3);
    chk("lit_model_count", 0, 32'(mq[0].size()), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("lit_basic_valid", 0, 32'(rd_valid_w[0]), 32'd1);
      chk("lit_basic_pc", 0, rd_pc_w[0], 32'(4 * i));
      chk("lit_basic_reg", 0, 32'(rd_reg_w[0]), 32'(i + 1));
      chk("lit_basic_data", 0, rd_data_w[0], 32'(5 * (i + 1)));
      step();
    end
    chk("lit_basic_empty", 0, 32'(rd_valid_w[0]), 32'd0);
    rd_ready = 1'b0;

    // x0 writes are counted but not stored
    pulse_arm();
    ev(32'h10, 5'd0, 32'd1);
    ev(32'h14, 5'd1, 32'd2);
    ev(32'h18, 5'd0, 32'd3);
    chk("lit_x0_count", 0, 32'(count_w[0]), 32'd1);
    chk("lit_x0_retire", 0, retire_w[0], 32'd3);
    chk("lit_x0_cycle", 0, cycle_w[0], 32'd3);
    pulse_stop();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

    // stop-mode and wrap-mode on the depth-4 instances
    pulse_arm();
    for (int d = 1; d <= 6; d++) begin
      ev(32'(4 * d), 5'(d), 32'(d));
      if (d == 5) begin
        chk("lit_stopmode_done", 1, 32'(state_w[1]), 32'd3);
        chk("lit_stopmode_ovf", 1, 32'(overflow_w[1]), 32'd1);
      end
    end
    chk("lit_stopmode_count", 1, 32'(count_w[1]), 32'd4);
    chk("lit_wrap_count", 2, 32'(count_w[2]), 32'd4);
    chk("lit_wrap_ovf", 2, 32'(overflow_w[2]), 32'd1);
    chk("lit_wrap_state", 2, 32'(state_w[2]), 32'd1);
    pulse_stop();
    step(); step();
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_stopmode_data", 1, rd_data_w[1], 32'(i + 1));
      chk("lit_wrap_data", 2, rd_data_w[2], 32'(i + 3));
      step();
    end
    step(); step();
    rd_ready = 1'b0;

    // register/data trigger with post window
    trig_en = 1'b1; trig_rd = 5'd3; trig_data_en = 1'b1; trig_data = 32'd15;
    pulse_arm();
    ev(32'h100, 5'd3, 32'd7);
    chk("lit_trig_nofire", 0, 32'(triggered_w[0]), 32'd0);
    ev(32'h104, 5'd3, 32'd15);
    chk("lit_trig_fire", 0, 32'(triggered_w[0]), 32'd1);
    chk("lit_trig_post", 0, 32'(state_w[0]), 32'd2);
    ev(32'h108, 5'd4, 32'd40);
    ev(32'h10c, 5'd5, 32'd50);
    chk("lit_trig_done", 0, 32'(state_w[0]), 32'd3);
    ev(32'h110, 5'd6, 32'd60);
    chk("lit_trig_count", 0, 32'(count_w[0]), 32'd4);
    t_reg  = '{5'd3, 5'd3, 5'd4, 5'd5};
    t_data = '{32'd7, 32'd15, 32'd40, 32'd50};
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("lit_trig_reg", 0, 32'(rd_reg_w[0]), 32'(t_reg[i]));
      chk("lit_trig_data", 0, rd_data_w[0], t_data[i]);
      step();
    end
    rd_ready = 1'b0;
    trig_en = 1'b0; trig_data_en = 1'b0;

    // arm beats a same-cycle writeback; reset mid-readout
    arm = 1'b1; wb_valid = 1'b1; wb_pc = 32'h200; wb_rd = 5'd1; wb_data = 32'd99;
    step();
    arm = 1'b0; wb_valid = 1'b0;
    chk("lit_arm_count", 0, 32'(count_w[0]), 32'd0);
    chk("lit_arm_state", 0, 32'(state_w[0]), 32'd1);
    ev(32'h204, 5'd1, 32'd1);
    ev(32'h208, 5'd2, 32'd2);
    pulse_stop();
    step();
    chk("lit_pre_reset_valid", 0, 32'(rd_valid_w[0]), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("lit_rst_state", 0, 32'(state_w[0]), 32'd0);
    chk("lit_rst_count", 0, 32'(count_w[0]), 32'd0);
    chk("lit_rst_valid", 0, 32'(rd_valid_w[0]), 32'd0);
    chk("lit_rst_data", 0, rd_data_w[0], 32'd0);
    chk("lit_rst_cycle", 0, cycle_w[0], 32'd0);
    step(); step();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
